// File: rtl/card_pkg.sv
// Shared card-interface definitions: code width, deck size, card type and
// the collector's state encoding.
package card_pkg;

    localparam int unsigned CARD_W    = 6;
    localparam int unsigned NUM_CARDS = 52;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned RETRY_W   = 8;
    localparam int unsigned ST_W      = 3;

    typedef logic [CARD_W-1:0] card_t;

    localparam card_t INVALID_CARD = 6'h3F;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_REQ   = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [ST_W-1:0] ST_CHECK = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;
    localparam logic [ST_W-1:0] ST_ERR   = 3'd5;

endpackage

// File: rtl/dup_checker.sv
// Flags whether a candidate card already sits in one of the occupied hand slots.
module dup_checker
    import card_pkg::*;
#(
    parameter int unsigned HAND_SIZE = 5
) (
    input  logic [CARD_W-1:0]           i_cand,
    input  logic [CARD_W*HAND_SIZE-1:0] i_slots,
    input  logic [CNT_W-1:0]            i_count,
    output logic                        o_is_dup
);

    // Compare against every slot; only slots below the fill count take part.
    always_comb begin
        o_is_dup = 1'b0;
        for (int unsigned k = 0; k < HAND_SIZE; k++) begin
            if ((CNT_W'(k) < i_count) && (i_slots[k*CARD_W +: CARD_W] == i_cand)) begin
                o_is_dup = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hand_collector.sv
// Draws cards from the dealer one at a time, keeps the valid, in-range,
// unique ones until a full hand is collected, and gives up after too many
// consecutive rejections for one slot.
module hand_collector
    import card_pkg::*;
#(
    parameter int unsigned HAND_SIZE = 5,
    parameter int unsigned RESP_LAT  = 2,
    parameter int unsigned MAX_RETRY = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        deal_valid,
    input  logic [CARD_W-1:0]           deal_card,
    output logic                        draw_card,
    output logic [CARD_W*HAND_SIZE-1:0] hand,
    output logic [CNT_W-1:0]            hand_count,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [RETRY_W-1:0]          retries
);

    localparam int unsigned WAIT_W    = $clog2(RESP_LAT + 1);
    localparam int unsigned WAIT_LAST = (RESP_LAT > 1) ? (RESP_LAT - 2) : 0;

    logic [ST_W-1:0]             r_state;
    logic [ST_W-1:0]             w_state_nxt;
    logic [CARD_W*HAND_SIZE-1:0] r_hand;
    logic [CARD_W*HAND_SIZE-1:0] w_hand_nxt;
    logic [CNT_W-1:0]            r_count;
    logic [CNT_W-1:0]            w_count_nxt;
    logic [RETRY_W-1:0]          r_retries;
    logic [RETRY_W-1:0]          w_retries_nxt;
    logic [WAIT_W-1:0]           r_wait;
    logic [WAIT_W-1:0]           w_wait_nxt;
    logic                        r_draw;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_error;

    logic                        w_is_dup;
    logic                        w_in_range;
    logic                        w_accept;

    dup_checker #(
        .HAND_SIZE (HAND_SIZE)
    ) u_dup_checker (
        .i_cand   (deal_card),
        .i_slots  (r_hand),
        .i_count  (r_count),
        .o_is_dup (w_is_dup)
    );

    // Acceptance test applied to the dealer response in the CHECK cycle.
    assign w_in_range = ({1'b0, deal_card} < (CARD_W+1)'(NUM_CARDS));
    assign w_accept   = deal_valid && w_in_range && !w_is_dup;

    // Next-state and next-datapath decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_hand_nxt    = r_hand;
        w_count_nxt   = r_count;
        w_retries_nxt = r_retries;
        w_wait_nxt    = r_wait;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_hand_nxt    = '0;
                    w_count_nxt   = '0;
                    w_retries_nxt = '0;
                    w_state_nxt   = ST_REQ;
                end
            end

            ST_REQ: begin
                w_wait_nxt = '0;
                if (RESP_LAT > 1) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_CHECK;
                end
            end

            ST_WAIT: begin
                if (r_wait == WAIT_W'(WAIT_LAST)) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end

            ST_CHECK: begin
                if (w_accept) begin
                    for (int unsigned k = 0; k < HAND_SIZE; k++) begin
                        if (CNT_W'(k) == r_count) begin
                            w_hand_nxt[k*CARD_W +: CARD_W] = deal_card;
                        end
                    end
                    w_count_nxt   = r_count + CNT_W'(1);
                    w_retries_nxt = '0;
                    if (w_count_nxt == CNT_W'(HAND_SIZE)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end else begin
                    w_retries_nxt = r_retries + RETRY_W'(1);
                    if (w_retries_nxt == RETRY_W'(MAX_RETRY)) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_hand    <= '0;
            r_count   <= '0;
            r_retries <= '0;
            r_wait    <= '0;
            r_draw    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hand    <= w_hand_nxt;
            r_count   <= w_count_nxt;
            r_retries <= w_retries_nxt;
            r_wait    <= w_wait_nxt;
            r_draw    <= (w_state_nxt == ST_REQ);
            r_busy    <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_WAIT) ||
                         (w_state_nxt == ST_CHECK);
            r_done    <= (w_state_nxt == ST_DONE);
            r_error   <= (w_state_nxt == ST_ERR);
        end
    end

    assign draw_card  = r_draw;
    assign hand       = r_hand;
    assign hand_count = r_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign retries    = r_retries;

endmodule

// File: tb/tb_hand_collector.sv
// Directed bench for hand_collector: a scripted dealer answers each draw
// pulse, and a draw-period level model predicts every output each cycle.
module tb_hand_collector;
    import card_pkg::*;

    localparam int HS = 5;
    localparam int RL = 2;
    localparam int MR = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              deal_valid;
    logic [CARD_W-1:0] deal_card;
    logic              draw_card;
    logic [CARD_W*HS-1:0] hand;
    logic [CNT_W-1:0]  hand_count;
    logic              busy;
    logic              done;
    logic              error;
    logic [RETRY_W-1:0] retries;

    always #5 clk = ~clk;

    hand_collector #(
        .HAND_SIZE (HS),
        .RESP_LAT  (RL),
        .MAX_RETRY (MR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .deal_valid (deal_valid),
        .deal_card  (deal_card),
        .draw_card  (draw_card),
        .hand       (hand),
        .hand_count (hand_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .retries    (retries)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Dealer script: {valid, card} per draw; an empty script answers invalid.
    logic [6:0] resp_q[$];

    // Reference model: time is counted within a draw period of RL+1 cycles.
    bit m_valid = 1'b0;
    bit m_active;
    int m_t;
    int m_hand[HS];
    int m_count;
    int m_retries;
    bit m_done;
    bit m_error;

    int draw_cnt = 0;
    int max_ret  = 0;

    function automatic logic [CARD_W*HS-1:0] model_hand();
        logic [CARD_W*HS-1:0] v;
        v = '0;
        for (int k = 0; k < m_count; k++) v[k*CARD_W +: CARD_W] = CARD_W'(m_hand[k]);
        return v;
    endfunction

    function automatic bit in_hand(input int c);
        for (int k = 0; k < m_count; k++) if (m_hand[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_count   = 0;
        m_retries = 0;
        for (int k = 0; k < HS; k++) m_hand[k] = 0;
    endtask

    // Compare, then drive the dealer, then advance the model to the next edge.
    initial begin
        bit ok;
        deal_valid = 1'b0;
        deal_card  = INVALID_CARD;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("draw_card",  32'(draw_card),  32'(m_active && m_t == 0));
                chk("busy",       32'(busy),       32'(m_active));
                chk("done",       32'(done),       32'(m_done));
                chk("error",      32'(error),      32'(m_error));
                chk("hand_count", 32'(hand_count), 32'(m_count));
                chk("retries",    32'(retries),    32'(m_retries));
                chk("hand",       32'(hand),       32'(model_hand()));
            end
            if (draw_card === 1'b1) begin
                draw_cnt++;
                if (resp_q.size() > 0) {deal_valid, deal_card} = resp_q.pop_front();
                else {deal_valid, deal_card} = {1'b0, INVALID_CARD};
            end
            if (int'(retries) > max_ret) max_ret = int'(retries);

            if (reset) begin
                m_valid  = 1'b1;
                m_active = 1'b0;
                m_t      = 0;
                m_done   = 1'b0;
                m_error  = 1'b0;
                model_clear();
            end else if (m_valid) begin
                if (m_active) begin
                    if (m_t == RL) begin
                        ok = deal_valid && (int'(deal_card) < 52) && !in_hand(int'(deal_card));
                        if (ok) begin
                            m_hand[m_count] = int'(deal_card);
                            m_count++;
                            m_retries = 0;
                            if (m_count == HS) begin m_active = 1'b0; m_done = 1'b1; end
                            else m_t = 0;
                        end else begin
                            m_retries++;
                            if (m_retries == MR) begin m_active = 1'b0; m_error = 1'b1; end
                            else m_t = 0;
                        end
                    end else begin
                        m_t++;
                    end
                end else if (start) begin
                    model_clear();
                    m_active = 1'b1;
                    m_t      = 0;
                    m_done   = 1'b0;
                    m_error  = 1'b0;
                end
            end
        end
    end

    task automatic push(input bit v, input int c);
        resp_q.push_back({v, CARD_W'(c)});
    endtask

    // Pulse start and wait for done/error; n = edges after the start edge.
    task automatic run_hand(input string name, input int poke_at, output int n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        chk({name, " cleared"}, {hand, hand_count, done}, 32'd0);
        while (!(done === 1'b1 || error === 1'b1) && n < 300) begin
            start = (n == poke_at);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (n >= 300) chk({name, " timeout"}, 32'(done | error), 32'd1);
    endtask

    initial begin
        int n;
        int d0;
        int k;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst draw",  32'(draw_card),  32'd0);
        chk("rst busy",  32'(busy),       32'd0);
        chk("rst done",  32'(done),       32'd0);
        chk("rst error", 32'(error),      32'd0);
        chk("rst count", 32'(hand_count), 32'd0);
        chk("rst retr",  32'(retries),    32'd0);
        chk("rst hand",  32'(hand),       32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Clean hand.
        push(1, 3); push(1, 17); push(1, 40); push(1, 51); push(1, 0);
        d0 = draw_cnt;
        run_hand("t1", -1, n);
        chk("t1 latency", 32'(n), 32'd15);
        chk("t1 hand", 32'(hand), 32'({6'd0, 6'd51, 6'd40, 6'd17, 6'd3}));
        chk("t1 count", 32'(hand_count), 32'd5);
        chk("t1 draws", 32'(draw_cnt - d0), 32'd5);
        chk("t1 done", 32'(done), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Invalid responses on slot 1 (restart from DONE).
        push(1, 3); push(0, 9); push(0, 9); push(1, 9); push(1, 20); push(1, 30); push(1, 40);
        d0 = draw_cnt; max_ret = 0;
        run_hand("t2", -1, n);
        chk("t2 slot1", 32'(hand[11:6]), 32'd9);
        chk("t2 hand", 32'(hand), 32'({6'd40, 6'd30, 6'd20, 6'd9, 6'd3}));
        chk("t2 draws", 32'(draw_cnt - d0), 32'd7);
        chk("t2 maxret", 32'(max_ret), 32'd2);

        // Duplicate card, with a stray start while busy.
        push(1, 17); push(1, 17); push(1, 5); push(1, 6); push(1, 7); push(1, 8);
        d0 = draw_cnt; max_ret = 0;
        run_hand("t3", 4, n);
        chk("t3 hand", 32'(hand), 32'({6'd8, 6'd7, 6'd6, 6'd5, 6'd17}));
        chk("t3 draws", 32'(draw_cnt - d0), 32'd6);
        chk("t3 maxret", 32'(max_ret), 32'd1);
        chk("t3 latency", 32'(n), 32'd18);

        // Out-of-range card code.
        push(1, 55); push(1, 1); push(1, 2); push(1, 3); push(1, 4); push(1, 5);
        d0 = draw_cnt; max_ret = 0;
        run_hand("t4", -1, n);
        chk("t4 hand", 32'(hand), 32'({6'd5, 6'd4, 6'd3, 6'd2, 6'd1}));
        chk("t4 draws", 32'(draw_cnt - d0), 32'd6);
        chk("t4 maxret", 32'(max_ret), 32'd1);

        // Dealer never valid: retry limit then error.
        d0 = draw_cnt;
        run_hand("t5", -1, n);
        chk("t5 latency", 32'(n), 32'd45);
        chk("t5 error", 32'(error), 32'd1);
        chk("t5 count", 32'(hand_count), 32'd0);
        chk("t5 draws", 32'(draw_cnt - d0), 32'd15);
        repeat (20) @(posedge clk);
        #1;
        chk("t5 quiet", 32'(draw_cnt - d0), 32'd15);
        chk("t5 hold", 32'(error), 32'd1);

        // Reset during WAIT of the third card, then a normal hand.
        push(1, 1); push(1, 2); push(1, 3); push(1, 4); push(1, 5);
        d0 = draw_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while ((draw_cnt - d0) < 3 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t6 third draw", 32'(draw_cnt - d0), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 count", 32'(hand_count), 32'd0);
        chk("t6 draw", 32'(draw_card), 32'd0);
        resp_q.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("t6 quiet", 32'(draw_cnt - d0), 32'd3);
        push(1, 10); push(1, 11); push(1, 12); push(1, 13); push(1, 14);
        run_hand("t6b", -1, n);
        chk("t6b latency", 32'(n), 32'd15);
        chk("t6b hand", 32'(hand), 32'({6'd14, 6'd13, 6'd12, 6'd11, 6'd10}));

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
